// File: rtl/packet_receiver_pkg.sv
// Shared definitions for packet_receiver: FSM states, frame field layout,
// preamble/SFD bytes, default header values and the byte-wide CRC-32 step.
package packet_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FCS,
        ST_CHECK,
        ST_DROP
    } rx_state_t;

    localparam int DEST_BYTES  = 6;
    localparam int SRC_BYTES   = 6;
    localparam int TYPE_BYTES  = 2;
    localparam int TICKS_BYTES = 8;
    localparam int FCS_BYTES   = 4;

    localparam int SRC_OFS   = DEST_BYTES;
    localparam int TYPE_OFS  = SRC_OFS + SRC_BYTES;
    localparam int TICKS_OFS = TYPE_OFS + TYPE_BYTES;
    localparam int HDR_BYTES = TICKS_OFS + TICKS_BYTES;

    localparam logic [2:0] PREAMBLE_MAX  = 3'd7;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] CTL_VALID = 2'b11;
    localparam logic [1:0] CTL_IDLE  = 2'b00;

    localparam logic [15:0] DEFAULT_ETHERTYPE     = 16'h9800;
    localparam int          DEFAULT_PAYLOAD_BYTES = 1024;
    localparam logic [47:0] DEFAULT_SRC_MAC       = 48'h000102030409;

    // Reflected CRC-32 (poly 0x04C11DB7), data consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/packet_receiver_rx_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator; crc is the final (inverted) value
// of everything accepted since the last init.
module rx_crc32
    import packet_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            lfsr_reg <= 32'hFFFFFFFF;
        end else if (en) begin
            lfsr_reg <= crc32_byte(lfsr_reg, data);
        end
    end

    assign crc = ~lfsr_reg;

endmodule

// File: rtl/packet_receiver.sv
// GMII-style frame receiver with FCS check and ping-pong payload buffer.
// Define PACKET_RECEIVER_SRC_FILTER_EN to reject frames whose source MAC differs from SRC_MAC.
module packet_receiver
    import packet_receiver_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE     = DEFAULT_ETHERTYPE,
    parameter int          PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES
`ifdef PACKET_RECEIVER_SRC_FILTER_EN
    ,
    parameter logic [47:0] SRC_MAC       = DEFAULT_SRC_MAC
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       rx_data,
    input  logic [1:0]                       rx_ctl,
    input  logic [$clog2(PAYLOAD_BYTES)-1:0] rd_addr,
    output logic [7:0]                       rd_data,
    output logic [63:0]                      ticks,
    output logic                             frame_good,
    output logic                             frame_bad,
    output logic [15:0]                      good_count,
    output logic [15:0]                      bad_count,
    output logic                             rd_bank
);

    localparam int ADDR_W = $clog2(PAYLOAD_BYTES);
    localparam int CNT_W  = (ADDR_W > 5) ? ADDR_W : 5;

    rx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        pre_cnt_reg, pre_cnt_next;
    logic              err_reg, err_next;
    logic [63:0]       stage_reg, stage_next;
    logic [31:0]       fcs_reg, fcs_next;
    logic              rd_bank_reg, rd_bank_next;
    logic [63:0]       ticks_reg, ticks_next;
    logic              good_reg, good_next;
    logic              bad_reg, bad_next;
    logic [15:0]       good_count_reg, good_count_next;
    logic [15:0]       bad_count_reg, bad_count_next;
    logic              rd_sel_reg;

    logic              crc_init;
    logic              crc_en;
    logic [31:0]       crc_value;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              abort;
    logic              src_err;

    wire rx_valid = (rx_ctl == CTL_VALID);
    wire rx_idle  = (rx_ctl == CTL_IDLE);

    assign wr_bank = ~rd_bank_reg;
    assign wr_addr = cnt_reg[ADDR_W-1:0];

    rx_crc32 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (rx_data),
        .crc   (crc_value)
    );

`ifdef PACKET_RECEIVER_SRC_FILTER_EN
    logic [SRC_BYTES-1:0] src_byte_err;
    genvar gi;
    generate
        for (gi = 0; gi < SRC_BYTES; gi++) begin : g_src
            assign src_byte_err[gi] = (cnt_reg == CNT_W'(SRC_OFS + gi)) &&
                                      (rx_data != SRC_MAC[47 - 8*gi -: 8]);
        end
    endgenerate
    assign src_err = |src_byte_err;
`else
    assign src_err = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pre_cnt_next    = pre_cnt_reg;
        err_next        = err_reg;
        stage_next      = stage_reg;
        fcs_next        = fcs_reg;
        rd_bank_next    = rd_bank_reg;
        ticks_next      = ticks_reg;
        good_next       = 1'b0;
        bad_next        = 1'b0;
        good_count_next = good_count_reg;
        bad_count_next  = bad_count_reg;
        crc_init        = 1'b0;
        crc_en          = 1'b0;
        wr_en           = 1'b0;
        abort           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        state_next   = ST_PREAMBLE;
                        pre_cnt_next = 3'd1;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (rx_valid) begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        if (pre_cnt_reg == PREAMBLE_MAX) begin
                            state_next = ST_DROP;
                        end else begin
                            pre_cnt_next = pre_cnt_reg + 3'd1;
                        end
                    end else if (rx_data == SFD_BYTE) begin
                        state_next = ST_HEADER;
                        crc_init   = 1'b1;
                        cnt_next   = '0;
                        err_next   = 1'b0;
                    end else begin
                        state_next = ST_DROP;
                    end
                end else begin
                    state_next = rx_idle ? ST_IDLE : ST_DROP;
                end
            end

            ST_HEADER: begin
                if (rx_valid) begin
                    crc_en = 1'b1;
                    if ((cnt_reg == CNT_W'(TYPE_OFS) && rx_data != ETHERTYPE[15:8]) ||
                        (cnt_reg == CNT_W'(TYPE_OFS + 1) && rx_data != ETHERTYPE[7:0]) ||
                        src_err) begin
                        err_next = 1'b1;
                    end
                    if (cnt_reg >= CNT_W'(TICKS_OFS)) begin
                        stage_next = {stage_reg[55:0], rx_data};
                    end
                    if (cnt_reg == CNT_W'(HDR_BYTES - 1)) begin
                        state_next = ST_PAYLOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    abort = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (rx_valid) begin
                    crc_en = 1'b1;
                    wr_en  = 1'b1;
                    if (cnt_reg == CNT_W'(PAYLOAD_BYTES - 1)) begin
                        state_next = ST_FCS;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    abort = 1'b1;
                end
            end

            ST_FCS: begin
                if (rx_valid) begin
                    fcs_next = {fcs_reg[23:0], rx_data};
                    if (cnt_reg == CNT_W'(FCS_BYTES - 1)) begin
                        state_next = ST_CHECK;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    abort = 1'b1;
                end
            end

            ST_CHECK: begin
                // The frame must be followed by idle, not more bytes, to count.
                if (rx_idle && crc_value == fcs_reg && !err_reg) begin
                    rd_bank_next    = ~rd_bank_reg;
                    ticks_next      = stage_reg;
                    good_next       = 1'b1;
                    good_count_next = good_count_reg + 16'd1;
                    state_next      = ST_IDLE;
                end else begin
                    bad_next       = 1'b1;
                    bad_count_next = bad_count_reg + 16'd1;
                    state_next     = rx_idle ? ST_IDLE : ST_DROP;
                end
            end

            ST_DROP: begin
                if (rx_idle) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        if (abort) begin
            bad_next       = 1'b1;
            bad_count_next = bad_count_reg + 16'd1;
            state_next     = rx_idle ? ST_IDLE : ST_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            pre_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            stage_reg      <= '0;
            fcs_reg        <= '0;
            rd_bank_reg    <= 1'b0;
            ticks_reg      <= '0;
            good_reg       <= 1'b0;
            bad_reg        <= 1'b0;
            good_count_reg <= '0;
            bad_count_reg  <= '0;
            rd_sel_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pre_cnt_reg    <= pre_cnt_next;
            err_reg        <= err_next;
            stage_reg      <= stage_next;
            fcs_reg        <= fcs_next;
            rd_bank_reg    <= rd_bank_next;
            ticks_reg      <= ticks_next;
            good_reg       <= good_next;
            bad_reg        <= bad_next;
            good_count_reg <= good_count_next;
            bad_count_reg  <= bad_count_next;
            rd_sel_reg     <= rd_bank_reg;
        end
    end

    // Both banks are read every cycle; the bank select is sampled with the address.
    logic [7:0] bank_q [2];

    genvar gb;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bank
            logic [7:0] mem [PAYLOAD_BYTES];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_bank == 1'(gb)) begin
                    mem[wr_addr] <= rx_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= mem[rd_addr];
                end
            end

            assign bank_q[gb] = q_reg;
        end
    endgenerate

    assign rd_data    = rd_sel_reg ? bank_q[1] : bank_q[0];
    assign ticks      = ticks_reg;
    assign frame_good = good_reg;
    assign frame_bad  = bad_reg;
    assign good_count = good_count_reg;
    assign bad_count  = bad_count_reg;
    assign rd_bank    = rd_bank_reg;

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver: directed and random frames checked
// against a frame-level outcome model and a copy of the committed payload.
module tb_packet_receiver;

    localparam int PB = 1024;
    localparam logic [15:0] ETYPE  = 16'h9800;
    localparam logic [47:0] MY_SRC = 48'h000102030409;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic [1:0]  rx_ctl;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [63:0] ticks;
    logic        frame_good;
    logic        frame_bad;
    logic [15:0] good_count;
    logic [15:0] bad_count;
    logic        rd_bank;

    always #5 clk = ~clk;

    packet_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ctl     (rx_ctl),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ticks      (ticks),
        .frame_good (frame_good),
        .frame_bad  (frame_bad),
        .good_count (good_count),
        .bad_count  (bad_count),
        .rd_bank    (rd_bank)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int good_pulses = 0;
    int bad_pulses  = 0;
    always @(negedge clk) begin
        if (frame_good === 1'b1) good_pulses++;
        if (frame_bad === 1'b1) bad_pulses++;
    end

    // Reference model state
    logic [31:0] crc_tbl [256];
    logic [7:0]  pay [PB];
    logic [7:0]  exp_mem [PB];
    logic [7:0]  body [$];
    logic        exp_bank;
    logic [63:0] exp_ticks;
    logic [15:0] exp_good, exp_bad;
    bit          mem_valid;
    int          g_base, b_base;

    task automatic model_reset();
        exp_bank  = 1'b0;
        exp_ticks = '0;
        exp_good  = '0;
        exp_bad   = '0;
        mem_valid = 1'b0;
    endtask

    task automatic model_commit(input logic [63:0] tk);
        exp_bank  = ~exp_bank;
        exp_ticks = tk;
        exp_good  = exp_good + 16'd1;
        for (int i = 0; i < PB; i++) exp_mem[i] = pay[i];
        mem_valid = 1'b1;
    endtask

    function automatic logic [31:0] frame_crc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_tbl[c[7:0] ^ body[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic build(input logic [47:0] src, input logic [15:0] typ, input logic [63:0] tk);
        body.delete();
        for (int i = 0; i < 6; i++) body.push_back(8'($urandom));
        for (int i = 5; i >= 0; i--) body.push_back(src[8*i +: 8]);
        body.push_back(typ[15:8]);
        body.push_back(typ[7:0]);
        for (int i = 7; i >= 0; i--) body.push_back(tk[8*i +: 8]);
        for (int i = 0; i < PB; i++) body.push_back(pay[i]);
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_ctl  = c;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 8'h00);
    endtask

    task automatic mark();
        g_base = good_pulses;
        b_base = bad_pulses;
    endtask

    // Sends preamble, SFD, body and FCS, then one idle gap cycle.
    // cut >= 0 replaces byte cut with cut_ctl and ends the frame there.
    task automatic send(input int npre, input int cut, input logic [1:0] cut_ctl,
                        input logic [31:0] fcs_xor, input bit trailing);
        logic [31:0] fcs;
        int total;
        fcs = frame_crc() ^ fcs_xor;
        total = body.size() + 4;
        for (int i = 0; i < npre; i++) drive(2'b11, 8'h55);
        drive(2'b11, 8'hD5);
        for (int i = 0; i < total; i++) begin
            if (i == cut) begin
                drive(cut_ctl, 8'hEE);
                if (cut_ctl != 2'b00) drive(cut_ctl, 8'hEE);
                break;
            end
            if (i < body.size()) drive(2'b11, body[i]);
            else drive(2'b11, fcs[31 - 8*(i - body.size()) -: 8]);
        end
        if (trailing && cut < 0) drive(2'b11, 8'hAA);
        idle(1);
    endtask

    task automatic read_chk(input int a);
        rd_addr = 10'(a);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", a), rd_data, exp_mem[a]);
    endtask

    task automatic settle(input string tag, input int want_good, input int want_bad);
        idle(4);
        @(negedge clk);
        check({tag, "_good_pulses"}, 64'(good_pulses - g_base), 64'(want_good));
        check({tag, "_bad_pulses"}, 64'(bad_pulses - b_base), 64'(want_bad));
        check({tag, "_good_count"}, good_count, exp_good);
        check({tag, "_bad_count"}, bad_count, exp_bad);
        check({tag, "_rd_bank"}, rd_bank, exp_bank);
        check({tag, "_ticks"}, ticks, exp_ticks);
        if (mem_valid) begin
            read_chk(5);
            read_chk(0);
            read_chk(PB - 1);
            read_chk($urandom_range(PB - 1));
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < PB; i++) pay[i] = 8'($urandom);
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [63:0] tk, tk2;
        int kind, npre, cut;
        logic [1:0] cctl;
        logic [31:0] fx;
        bit trail;
        logic [15:0] typ;

        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end

        reset   = 1'b1;
        rx_ctl  = 2'b00;
        rx_data = 8'h00;
        rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_bank", rd_bank, 1'b0);
        check("rst_ticks", ticks, 64'h0);
        check("rst_good_count", good_count, 16'h0);
        check("rst_bad_count", bad_count, 16'h0);
        check("rst_frame_good", frame_good, 1'b0);
        check("rst_frame_bad", frame_bad, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Directed good frame with counting payload
        for (int i = 0; i < PB; i++) pay[i] = 8'(i);
        tk = 64'h0123456789ABCDEF;
        build(MY_SRC, ETYPE, tk);
        mark();
        send(7, -1, 2'b00, 32'h0, 1'b0);
        model_commit(tk);
        settle("good1", 1, 0);

        // Same frame, FCS byte 2 corrupted
        mark();
        send(7, -1, 2'b00, 32'h0000FF00, 1'b0);
        exp_bad++;
        settle("fcs_bad", 0, 1);

        // Wrong type with matching FCS
        rand_payload();
        build(MY_SRC, 16'h0800, rand64());
        mark();
        send(7, -1, 2'b00, 32'h0, 1'b0);
        exp_bad++;
        settle("type_bad", 0, 1);
        for (int i = 0; i < PB; i++) pay[i] = exp_mem[i];

        // Truncation at payload byte 300, then a good frame
        build(MY_SRC, ETYPE, rand64());
        mark();
        send(7, 22 + 300, 2'b00, 32'h0, 1'b0);
        exp_bad++;
        settle("trunc", 0, 1);
        rand_payload();
        tk = rand64();
        build(MY_SRC, ETYPE, tk);
        mark();
        send(7, -1, 2'b00, 32'h0, 1'b0);
        model_commit(tk);
        settle("after_trunc", 1, 0);

        // Back-to-back good frames with a single idle gap
        mark();
        rand_payload();
        tk = rand64();
        build(MY_SRC, ETYPE, tk);
        send(7, -1, 2'b00, 32'h0, 1'b0);
        model_commit(tk);
        rand_payload();
        tk2 = rand64();
        build(MY_SRC, ETYPE, tk2);
        send(7, -1, 2'b00, 32'h0, 1'b0);
        model_commit(tk2);
        settle("b2b", 2, 0);

        // Reset in the middle of the header
        mark();
        build(MY_SRC, ETYPE, rand64());
        for (int i = 0; i < 7; i++) drive(2'b11, 8'h55);
        drive(2'b11, 8'hD5);
        for (int i = 0; i < 10; i++) drive(2'b11, body[i]);
        reset = 1'b1;
        idle(2);
        #1;
        reset = 1'b0;
        model_reset();
        settle("mid_reset", 0, 0);
        rand_payload();
        tk = rand64();
        build(MY_SRC, ETYPE, tk);
        mark();
        send(7, -1, 2'b00, 32'h0, 1'b0);
        model_commit(tk);
        settle("post_reset", 1, 0);

        // Source address one off from the accepted one
        rand_payload();
        tk = rand64();
        build(48'h00010203040A, ETYPE, tk);
        mark();
        send(7, -1, 2'b00, 32'h0, 1'b0);
`ifdef PACKET_RECEIVER_SRC_FILTER_EN
        exp_bad++;
        for (int i = 0; i < PB; i++) pay[i] = exp_mem[i];
        settle("src_mismatch", 0, 1);
`else
        model_commit(tk);
        settle("src_ignored", 1, 0);
`endif

        // Random frames
        for (int f = 0; f < 10; f++) begin
            kind  = $urandom_range(5);
            npre  = $urandom_range(7, 1);
            cut   = -1;
            cctl  = 2'b00;
            fx    = 32'h0;
            trail = 1'b0;
            typ   = ETYPE;
            case (kind)
                1: fx = 32'($urandom) | 32'h1;
                2: typ = ETYPE ^ 16'($urandom_range(65535, 1));
                3: begin
                    cut  = $urandom_range(22 + PB + 3);
                    cctl = 2'($urandom_range(2));
                end
                4: trail = 1'b1;
                5: npre = 8;
                default: ;
            endcase
            rand_payload();
            tk = rand64();
            build(MY_SRC, typ, tk);
            mark();
            send(npre, cut, cctl, fx, trail);
            if (kind == 0) begin
                model_commit(tk);
                settle($sformatf("rnd%0d_good", f), 1, 0);
            end else if (kind == 5) begin
                settle($sformatf("rnd%0d_longpre", f), 0, 0);
            end else begin
                exp_bad++;
                settle($sformatf("rnd%0d_bad%0d", f, kind), 0, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
